// File: rtl/bar_led_serializer.sv
// Serializes one indicator bar array per ready/valid transfer onto a 74HC595-style
// chain: o_sdata/o_sclk for every bit, then an o_latch pulse.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | waiting for an array; i_ready high
// SHIFT_LO | o_sclk low, current bit on o_sdata (setup phase)
// SHIFT_HI | o_sclk high, o_sdata held (LED registers sample on the rise)
// LATCH    | o_latch high for latch_cycles cycles, then back to IDLE
module bar_led_serializer #(
    parameter int width        = 32,
    parameter int clk_div      = 4,
    parameter int latch_cycles = 2,
    parameter int msb_first    = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_valid,
    output logic             i_ready,
    input  logic [width-1:0] i_array,
    output logic             o_sclk,
    output logic             o_sdata,
    output logic             o_latch,
    output logic             o_busy
);

    localparam int IW = $clog2(width);
    localparam int DW = $clog2(clk_div + 1);
    localparam int LW = $clog2(latch_cycles + 1);

    localparam logic [IW-1:0] IDX_LAST = IW'(width - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(clk_div - 1);
    localparam logic [LW-1:0] LAT_LOAD = LW'(latch_cycles - 1);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] SHIFT_LO = 2'd1;
    localparam logic [1:0] SHIFT_HI = 2'd2;
    localparam logic [1:0] LATCH    = 2'd3;

    logic [1:0]       state;
    logic [width-1:0] shift_reg;
    logic [width-1:0] shift_next;
    logic [IW-1:0]    bit_idx;
    logic [DW-1:0]    div_cnt;
    logic [LW-1:0]    lat_cnt;
    logic             accept_bit;
    logic             next_bit;
    logic             div_tc;

    assign i_ready = (state == IDLE);
    assign div_tc  = (div_cnt == DIV_LAST);

    // The bit on the wire is always the head of shift_reg; shifting moves the
    // following bit into the head position.
    always_comb begin
        accept_bit = i_array[0];
        next_bit   = shift_reg[1];
        shift_next = {1'b0, shift_reg[width-1:1]};
        if (msb_first != 0) begin
            accept_bit = i_array[width-1];
            next_bit   = shift_reg[width-2];
            shift_next = {shift_reg[width-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            shift_reg <= '0;
            bit_idx   <= '0;
            div_cnt   <= '0;
            lat_cnt   <= '0;
            o_sclk    <= 1'b0;
            o_sdata   <= 1'b0;
            o_latch   <= 1'b0;
            o_busy    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        shift_reg <= i_array;
                        bit_idx   <= '0;
                        div_cnt   <= '0;
                        o_sdata   <= accept_bit;
                        o_sclk    <= 1'b0;
                        o_busy    <= 1'b1;
                        state     <= SHIFT_LO;
                    end
                end
                SHIFT_LO: begin
                    if (div_tc) begin
                        div_cnt <= '0;
                        o_sclk  <= 1'b1;
                        state   <= SHIFT_HI;
                    end else begin
                        div_cnt <= div_cnt + DW'(1);
                    end
                end
                SHIFT_HI: begin
                    if (div_tc) begin
                        div_cnt <= '0;
                        o_sclk  <= 1'b0;
                        if (bit_idx == IDX_LAST) begin
                            o_sdata <= 1'b0;
                            o_latch <= 1'b1;
                            lat_cnt <= LAT_LOAD;
                            state   <= LATCH;
                        end else begin
                            shift_reg <= shift_next;
                            bit_idx   <= bit_idx + IW'(1);
                            o_sdata   <= next_bit;
                            state     <= SHIFT_LO;
                        end
                    end else begin
                        div_cnt <= div_cnt + DW'(1);
                    end
                end
                LATCH: begin
                    if (lat_cnt == '0) begin
                        o_latch <= 1'b0;
                        o_busy  <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        lat_cnt <= lat_cnt - LW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bar_led_serializer.sv
// Bench for bar_led_serializer: three configurations (8-bit MSB-first, 8-bit
// LSB-first, 20-bit fast clock) checked against hand-computed serial frames.
module tb_bar_led_serializer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  valid = '0;
    logic [2:0]  ready, sclk, sdata, latch, busy;
    logic [7:0]  arr0 = '0;
    logic [7:0]  arr1 = '0;
    logic [19:0] arr2 = '0;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    bar_led_serializer #(.width(8), .clk_div(2), .latch_cycles(3), .msb_first(1)) u_msb (
        .clk(clk), .reset(rst_n), .i_valid(valid[0]), .i_ready(ready[0]), .i_array(arr0),
        .o_sclk(sclk[0]), .o_sdata(sdata[0]), .o_latch(latch[0]), .o_busy(busy[0]));

    bar_led_serializer #(.width(8), .clk_div(2), .latch_cycles(3), .msb_first(0)) u_lsb (
        .clk(clk), .reset(rst_n), .i_valid(valid[1]), .i_ready(ready[1]), .i_array(arr1),
        .o_sclk(sclk[1]), .o_sdata(sdata[1]), .o_latch(latch[1]), .o_busy(busy[1]));

    bar_led_serializer #(.width(20), .clk_div(1), .latch_cycles(1), .msb_first(1)) u_w20 (
        .clk(clk), .reset(rst_n), .i_valid(valid[2]), .i_ready(ready[2]), .i_array(arr2),
        .o_sclk(sclk[2]), .o_sdata(sdata[2]), .o_latch(latch[2]), .o_busy(busy[2]));

    // Serial-line monitor: what the external shift registers would see.
    logic [31:0] cap[3]      = '{32'd0, 32'd0, 32'd0};
    int          rises[3]    = '{0, 0, 0};
    int          lat_cyc[3]  = '{0, 0, 0};
    int          pulses[3]   = '{0, 0, 0};
    int          hold_err[3] = '{0, 0, 0};
    logic [2:0]  prev_sclk = '0;
    logic [2:0]  prev_sdata = '0;
    logic [2:0]  prev_latch = '0;

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (sclk[k] && !prev_sclk[k]) begin
                rises[k] <= rises[k] + 1;
                cap[k]   <= {cap[k][30:0], sdata[k]};
            end
            if (prev_sclk[k] && sclk[k] && (sdata[k] !== prev_sdata[k]))
                hold_err[k] <= hold_err[k] + 1;
            if (latch[k]) lat_cyc[k] <= lat_cyc[k] + 1;
            if (latch[k] && !prev_latch[k]) pulses[k] <= pulses[k] + 1;
        end
        prev_sclk  <= sclk;
        prev_sdata <= sdata;
        prev_latch <= latch;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input int k, input logic [31:0] a);
        case (k)
            0: arr0 = a[7:0];
            1: arr1 = a[7:0];
            default: arr2 = a[19:0];
        endcase
    endtask

    function automatic logic [31:0] mask_of(input int n);
        logic [31:0] m;
        m = (n >= 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
        return m;
    endfunction

    task automatic wait_idle(input int k, output int n);
        n = 0;
        while (ready[k] !== 1'b1 && n < 400) begin
            @(posedge clk);
            n++;
            #1;
        end
    endtask

    typedef struct {
        int          inst;
        logic [31:0] arr;
        logic [31:0] bits;
        int          nrise;
        int          len;
        int          lat;
    } vec_t;

    vec_t vecs[6];

    task automatic run_frame(input vec_t v);
        int r0, l0, p0, n;
        @(negedge clk);
        chk($sformatf("ready_pre[%0d]", v.inst), 32'(ready[v.inst]), 32'd1);
        r0 = rises[v.inst];
        l0 = lat_cyc[v.inst];
        p0 = pulses[v.inst];
        drive(v.inst, v.arr);
        valid[v.inst] = 1'b1;
        @(posedge clk);
        #1;
        valid[v.inst] = 1'b0;
        chk($sformatf("busy_after_accept[%0d]", v.inst), 32'(busy[v.inst]), 32'd1);
        wait_idle(v.inst, n);
        chk($sformatf("frame_len[%0d] %0h", v.inst, v.arr), 32'(n), 32'(v.len));
        chk($sformatf("rises[%0d] %0h", v.inst, v.arr), 32'(rises[v.inst] - r0), 32'(v.nrise));
        chk($sformatf("bits[%0d] %0h", v.inst, v.arr), cap[v.inst] & mask_of(v.nrise), v.bits);
        chk($sformatf("latch_cycles[%0d]", v.inst), 32'(lat_cyc[v.inst] - l0), 32'(v.lat));
        chk($sformatf("latch_pulses[%0d]", v.inst), 32'(pulses[v.inst] - p0), 32'd1);
        chk($sformatf("busy_end[%0d]", v.inst), 32'(busy[v.inst]), 32'd0);
    endtask

    initial begin
        int n, r0, p0;

        vecs[0] = '{0, 32'hB1,    32'hB1,    8,  35, 3};
        vecs[1] = '{0, 32'h00,    32'h00,    8,  35, 3};
        vecs[2] = '{1, 32'h01,    32'h80,    8,  35, 3};
        vecs[3] = '{1, 32'hB1,    32'h8D,    8,  35, 3};
        vecs[4] = '{2, 32'hA5C3F, 32'hA5C3F, 20, 41, 1};
        vecs[5] = '{2, 32'h80001, 32'h80001, 20, 41, 1};

        repeat (3) @(negedge clk);
        chk("reset_sclk",  32'(sclk),  32'd0);
        chk("reset_sdata", 32'(sdata), 32'd0);
        chk("reset_latch", 32'(latch), 32'd0);
        chk("reset_busy",  32'(busy),  32'd0);
        chk("reset_ready", 32'(ready), 32'h7);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 6; i++) run_frame(vecs[i]);

        // Back-to-back: i_valid held, second array presented right after the first acceptance.
        @(negedge clk);
        p0 = pulses[0];
        arr0 = 8'hFF;
        valid[0] = 1'b1;
        @(posedge clk);
        #1;
        arr0 = 8'h00;
        wait_idle(0, n);
        chk("b2b_len1", 32'(n), 32'd35);
        chk("b2b_bits1", cap[0] & 32'hFF, 32'hFF);
        @(posedge clk);
        #1;
        chk("b2b_ready_after_accept2", 32'(ready[0]), 32'd0);
        chk("b2b_busy_after_accept2", 32'(busy[0]), 32'd1);
        valid[0] = 1'b0;
        wait_idle(0, n);
        chk("b2b_len2", 32'(n), 32'd35);
        chk("b2b_bits2", cap[0] & 32'hFF, 32'h00);
        chk("b2b_pulses", 32'(pulses[0] - p0), 32'd2);

        // i_array toggling during the frame must not leak into the serial data.
        @(negedge clk);
        arr0 = 8'hA5;
        valid[0] = 1'b1;
        @(posedge clk);
        #1;
        valid[0] = 1'b0;
        n = 0;
        while (ready[0] !== 1'b1 && n < 400) begin
            @(negedge clk);
            arr0 = ~arr0;
            @(posedge clk);
            n++;
            #1;
        end
        chk("toggle_len", 32'(n), 32'd35);
        chk("toggle_bits", cap[0] & 32'hFF, 32'hA5);

        // Asynchronous reset after the 4th sclk rise aborts the frame without a latch.
        @(negedge clk);
        r0 = rises[0];
        p0 = pulses[0];
        arr0 = 8'hFF;
        valid[0] = 1'b1;
        @(posedge clk);
        #1;
        valid[0] = 1'b0;
        n = 0;
        while ((rises[0] - r0) < 4 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("abort_reached_4th_rise", 32'(rises[0] - r0), 32'd4);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_sclk",  32'(sclk[0]),  32'd0);
        chk("abort_sdata", 32'(sdata[0]), 32'd0);
        chk("abort_latch", 32'(latch[0]), 32'd0);
        chk("abort_busy",  32'(busy[0]),  32'd0);
        chk("abort_ready", 32'(ready[0]), 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("abort_no_latch", 32'(pulses[0] - p0), 32'd0);
        run_frame('{0, 32'h3C, 32'h3C, 8, 35, 3});

        for (int k = 0; k < 3; k++)
            chk($sformatf("sdata_hold[%0d]", k), 32'(hold_err[k]), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
